// File: rtl/mod6_ring_counter.sv
// mod6_ring_counter: six-stage one-hot ring counter (divide-by-6 phase sequencer).
// Optional macro MOD6_SELF_CORRECT_EN: reload the seed on a rotate edge when the ring is multi-hot.
module mod6_ring_counter #(
    parameter int PRESET_POS = 0
) (
    input  logic clk,
    input  logic clr,
    input  logic pre,
    output logic Qa,
    output logic Qb,
    output logic Qc,
    output logic Qd,
    output logic Qe,
    output logic Qf
);
    logic [5:0] ring_q, ring_d, seed;
    logic       fix;
    assign seed = 6'(1) << PRESET_POS;
`ifdef MOD6_SELF_CORRECT_EN
    assign fix = (ring_q & (ring_q - 6'd1)) != 6'd0;
`else
    assign fix = 1'b0;
`endif
    // next ring value: preset or self-correction loads the seed, otherwise rotate left with wrap
    always_comb ring_d = (pre || fix) ? seed : {ring_q[4:0], ring_q[5]};
    // clear has top priority and is sampled synchronously
    always_ff @(posedge clk)
        if (clr) ring_q <= '0;
        else     ring_q <= ring_d;
    assign {Qf, Qe, Qd, Qc, Qb, Qa} = ring_q;
endmodule

// File: tb/tb_mod6_ring_counter.sv
// tb_mod6_ring_counter: scoreboard bench with a position-based reference model.
module tb_mod6_ring_counter;
    localparam int PRESET_POS = 0;
`ifdef MOD6_SELF_CORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif
    logic clk = 1'b0, clr = 1'b1, pre = 1'b0;
    logic Qa, Qb, Qc, Qd, Qe, Qf;
    typedef struct { logic [5:0] exp; string name; } item_t;
    item_t sb[$];
    bit [5:0] m;
    int tests = 0, failed = 0;

    mod6_ring_counter #(.PRESET_POS(PRESET_POS)) dut (
        .clk(clk), .clr(clr), .pre(pre),
        .Qa(Qa), .Qb(Qb), .Qc(Qc), .Qd(Qd), .Qe(Qe), .Qf(Qf)
    );

    always #5 clk = ~clk;

    // reference: the ring is the set of lit stage positions; each edge moves every lit stage one place on
    task automatic step(input logic c, input logic p, input string nm);
        bit [5:0] n;
        n = '0;
        clr = c;
        pre = p;
        if (c) m = '0;
        else if (p || (SC && $countones(m) > 1)) begin
            m = '0;
            m[PRESET_POS] = 1'b1;
        end else begin
            for (int i = 0; i < 6; i++) if (m[i]) n[(i + 1) % 6] = 1'b1;
            m = n;
        end
        sb.push_back('{exp: m, name: nm});
        @(negedge clk);
    endtask

    // monitor: one registered output per edge, compared against the oldest expectation
    initial forever begin
        item_t it;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            it = sb.pop_front();
            tests++;
            if ({Qf, Qe, Qd, Qc, Qb, Qa} !== it.exp) begin
                failed++;
                $display("FAIL %s: got %b expected %b", it.name, {Qf, Qe, Qd, Qc, Qb, Qa}, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        step(1, 0, "reset");
        for (int i = 0; i < 6; i++) step(0, 0, "idle_zero");
        step(0, 1, "preset");
        for (int i = 0; i < 6; i++) step(0, 0, "rotate");
        step(0, 0, "rot_to_3");
        step(0, 0, "rot_to_3");
        step(1, 0, "clr_mid");
        step(0, 1, "preset_after_clr");
        step(1, 1, "clr_and_pre");
        step(0, 1, "pre_after_clr");
        for (int i = 0; i < 3; i++) step(0, 0, "rot_to_4");
        for (int i = 0; i < 3; i++) step(0, 1, "pre_held");
        step(0, 0, "release_pre");
        force dut.ring_q = 6'b000011;
        #1;
        release dut.ring_q;
        m = 6'b000011;
        step(0, 0, "multi_hot");
        for (int i = 0; i < 3; i++) step(0, 0, "multi_hot_next");
        step(0, 1, "reseed");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, "random");
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
